// File: rtl/multi_cycle_controller_pkg.sv
// Shared instruction format, opcode/funct constants and controller encodings
// for the multi-cycle MIPS datapath controller.
package multi_cycle_controller_pkg;

  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } instruction_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_ERROR  = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    CLS_OTHER   = 4'd0,
    CLS_RTYPE   = 4'd1,
    CLS_ORI     = 4'd2,
    CLS_LUI     = 4'd3,
    CLS_LW      = 4'd4,
    CLS_SW      = 4'd5,
    CLS_BEQ     = 4'd6,
    CLS_J       = 4'd7,
    CLS_JAL     = 4'd8,
    CLS_JR      = 4'd9,
    CLS_SYSCALL = 4'd10
  } instr_class_e;

  localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_GPR    = 2'd3;

  localparam int unsigned WAIT_COUNT_W = 8;

  function automatic logic is_mem_class(input instr_class_e c);
    return (c == CLS_LW) || (c == CLS_SW);
  endfunction

  function automatic logic is_alu_class(input instr_class_e c);
    return (c == CLS_RTYPE) || (c == CLS_ORI) || (c == CLS_LUI);
  endfunction

endpackage

// File: rtl/multi_cycle_controller_instr_class_decode.sv
// Combinational opcode/funct classifier feeding the controller's DECODE state.
module instr_class_decode
  import multi_cycle_controller_pkg::*;
(
  input  instruction_t i_instr,
  output instr_class_e o_class
);

  logic w_unused_fields;
  assign w_unused_fields = ^{i_instr.rs, i_instr.rt, i_instr.rd, i_instr.shamt};

  // Anything not explicitly supported falls through to CLS_OTHER and runs as a nop.
  always_comb begin
    o_class = CLS_OTHER;
    case (i_instr.opcode)
      OP_RTYPE: begin
        case (i_instr.funct)
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU: o_class = CLS_RTYPE;
          FN_JR:                            o_class = CLS_JR;
          FN_SYSCALL:                       o_class = CLS_SYSCALL;
          default:                          o_class = CLS_OTHER;
        endcase
      end
      OP_ORI:  o_class = CLS_ORI;
      OP_LUI:  o_class = CLS_LUI;
      OP_LW:   o_class = CLS_LW;
      OP_SW:   o_class = CLS_SW;
      OP_BEQ:  o_class = CLS_BEQ;
      OP_J:    o_class = CLS_J;
      OP_JAL:  o_class = CLS_JAL;
      default: o_class = CLS_OTHER;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle MIPS control FSM with fetch/memory wait timeout and sticky
// HALT/ERROR states.
module multi_cycle_controller
  import multi_cycle_controller_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic        zero,
  input  logic        imem_ready,
  input  logic        dm_ready,
  output logic        imem_req,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic [1:0]  pc_src,
  output logic        dm_req,
  output logic        dm_write_enabled,
  output logic        gpr_write_enabled,
  output logic        halted,
  output logic        mem_error,
  output logic [2:0]  state
);

  localparam logic [WAIT_COUNT_W-1:0] LP_WAIT_LAST = WAIT_COUNT_W'(WAIT_LIMIT - 1);

  state_e                  r_state;
  instr_class_e            r_class;
  logic [WAIT_COUNT_W-1:0] r_wait_count;
  logic                    r_started;

  state_e       w_next_state;
  instr_class_e w_decoded_class;
  logic         w_waiting;
  logic         w_timeout;
  logic         w_unused_zero;

  // The datapath ANDs pc_write_cond with the ALU flag itself.
  assign w_unused_zero = zero;

  instr_class_decode u_decode (
    .i_instr (instruction_t'(instruction)),
    .o_class (w_decoded_class)
  );

  assign w_waiting = r_started &&
                     (((r_state == ST_FETCH) && !imem_ready) ||
                      ((r_state == ST_MEM)   && !dm_ready));
  assign w_timeout = w_waiting && (r_wait_count == LP_WAIT_LAST);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_FETCH: begin
        if (imem_ready)     w_next_state = ST_DECODE;
        else if (w_timeout) w_next_state = ST_ERROR;
      end
      ST_DECODE: begin
        case (w_decoded_class)
          CLS_SYSCALL:             w_next_state = ST_HALT;
          CLS_J, CLS_JR, CLS_OTHER: w_next_state = ST_FETCH;
          CLS_JAL:                 w_next_state = ST_WB;
          default:                 w_next_state = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        if (r_class == CLS_BEQ)       w_next_state = ST_FETCH;
        else if (is_mem_class(r_class)) w_next_state = ST_MEM;
        else if (is_alu_class(r_class)) w_next_state = ST_WB;
        else                          w_next_state = ST_FETCH;
      end
      ST_MEM: begin
        if (dm_ready)       w_next_state = (r_class == CLS_LW) ? ST_WB : ST_FETCH;
        else if (w_timeout) w_next_state = ST_ERROR;
      end
      ST_WB:    w_next_state = ST_FETCH;
      ST_HALT:  w_next_state = ST_HALT;
      ST_ERROR: w_next_state = ST_ERROR;
      default:  w_next_state = ST_FETCH;
    endcase
  end

  // r_started holds the FSM idle for the first edge after reset release so
  // that imem_req only rises once the controller is actually running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_started    <= 1'b0;
      r_state      <= ST_FETCH;
      r_class      <= CLS_OTHER;
      r_wait_count <= '0;
    end else if (!r_started) begin
      r_started <= 1'b1;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_DECODE) r_class <= w_decoded_class;
      if (w_waiting && (w_next_state == r_state)) r_wait_count <= r_wait_count + 1'b1;
      else                                        r_wait_count <= '0;
    end
  end

  // Outputs are gated by r_started so reset removes every strobe asynchronously.
  always_comb begin
    imem_req          = 1'b0;
    ir_write          = 1'b0;
    pc_write          = 1'b0;
    pc_write_cond     = 1'b0;
    pc_src            = PC_SRC_SEQ;
    dm_req            = 1'b0;
    dm_write_enabled  = 1'b0;
    gpr_write_enabled = 1'b0;
    halted            = 1'b0;
    mem_error         = 1'b0;
    if (r_started) begin
      case (r_state)
        ST_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        ST_DECODE: begin
          case (w_decoded_class)
            CLS_J, CLS_JAL: begin
              pc_write = 1'b1;
              pc_src   = PC_SRC_JUMP;
            end
            CLS_JR: begin
              pc_write = 1'b1;
              pc_src   = PC_SRC_GPR;
            end
            default: pc_src = PC_SRC_SEQ;
          endcase
        end
        ST_EXEC: begin
          if (r_class == CLS_BEQ) begin
            pc_write_cond = 1'b1;
            pc_src        = PC_SRC_BRANCH;
          end
        end
        ST_MEM: begin
          dm_req           = 1'b1;
          dm_write_enabled = (r_class == CLS_SW);
        end
        ST_WB:    gpr_write_enabled = 1'b1;
        ST_HALT:  halted            = 1'b1;
        ST_ERROR: mem_error         = 1'b1;
        default:  imem_req          = 1'b0;
      endcase
    end
  end

  assign state = r_state;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Randomized self-checking bench: a per-instruction cycle plan built from the
// controller's rules is driven into the DUT and compared every cycle.
module tb_multi_cycle_controller;

  localparam int WAIT_LIMIT = 15;

  localparam int C_RTYPE = 0, C_ORI = 1, C_LUI = 2, C_LW = 3, C_SW = 4, C_BEQ = 5;
  localparam int C_J = 6, C_JAL = 7, C_JR = 8, C_SYSCALL = 9, C_OTHER = 10;

  localparam int S_FETCH = 0, S_DECODE = 1, S_EXEC = 2, S_MEM = 3;
  localparam int S_WB = 4, S_HALT = 5, S_ERROR = 6;

  typedef struct packed {
    logic [2:0] st;
    logic       imemReq;
    logic       irW;
    logic       pcW;
    logic       pcWC;
    logic [1:0] pcSrc;
    logic       dmReq;
    logic       dmW;
    logic       gprW;
    logic       halted;
    logic       memErr;
  } obs_t;

  typedef struct packed {
    logic imemRdy;
    logic dmRdy;
    logic zero;
    obs_t exp;
  } step_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] instruction = '0;
  logic        zero = 1'b0;
  logic        imem_ready = 1'b0;
  logic        dm_ready = 1'b0;
  logic        imem_req, ir_write, pc_write, pc_write_cond;
  logic [1:0]  pc_src;
  logic        dm_req, dm_write_enabled, gpr_write_enabled, halted, mem_error;
  logic [2:0]  state;

  step_t       plan[$];
  obs_t        obsQ[$];
  int          litQ[$];
  logic [31:0] planInstr;
  bit          planSticky;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  multi_cycle_controller #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .instruction       (instruction),
    .zero              (zero),
    .imem_ready        (imem_ready),
    .dm_ready          (dm_ready),
    .imem_req          (imem_req),
    .ir_write          (ir_write),
    .pc_write          (pc_write),
    .pc_write_cond     (pc_write_cond),
    .pc_src            (pc_src),
    .dm_req            (dm_req),
    .dm_write_enabled  (dm_write_enabled),
    .gpr_write_enabled (gpr_write_enabled),
    .halted            (halted),
    .mem_error         (mem_error),
    .state             (state)
  );

  function automatic obs_t sample();
    obs_t o;
    o.st      = state;
    o.imemReq = imem_req;
    o.irW     = ir_write;
    o.pcW     = pc_write;
    o.pcWC    = pc_write_cond;
    o.pcSrc   = pc_src;
    o.dmReq   = dm_req;
    o.dmW     = dm_write_enabled;
    o.gprW    = gpr_write_enabled;
    o.halted  = halted;
    o.memErr  = mem_error;
    return o;
  endfunction

  task automatic checkOutput(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got st/req/ir/pc/pcc/src/dreq/dw/gw/h/e=%b expected %b", name, act, exp);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] makeInstr(input int cls);
    logic [31:0] w;
    logic [5:0]  op, fn;
    logic [5:0]  badOps[4];
    logic [5:0]  badFns[4];
    badOps = '{6'h08, 6'h05, 6'h3F, 6'h0A};
    badFns = '{6'h00, 6'h2A, 6'h09, 6'h24};
    w  = $urandom;
    op = 6'h00;
    fn = w[5:0];
    case (cls)
      C_RTYPE:   fn = 6'h20 + 6'($urandom_range(0, 3));
      C_ORI:     op = 6'h0D;
      C_LUI:     op = 6'h0F;
      C_LW:      op = 6'h23;
      C_SW:      op = 6'h2B;
      C_BEQ:     op = 6'h04;
      C_J:       op = 6'h02;
      C_JAL:     op = 6'h03;
      C_JR:      fn = 6'h08;
      C_SYSCALL: fn = 6'h0C;
      default: begin
        if ($urandom_range(0, 1) == 1) op = badOps[$urandom_range(0, 3)];
        else                           fn = badFns[$urandom_range(0, 3)];
      end
    endcase
    return {op, w[25:6], fn};
  endfunction

  function automatic step_t blank(input int st);
    step_t e;
    e         = '0;
    e.exp.st  = 3'(st);
    e.imemRdy = 1'($urandom_range(0, 1));
    e.dmRdy   = 1'($urandom_range(0, 1));
    e.zero    = 1'($urandom_range(0, 1));
    return e;
  endfunction

  task automatic addWb();
    step_t e;
    e = blank(S_WB);
    e.exp.gprW = 1'b1;
    plan.push_back(e);
  endtask

  task automatic addSticky(input int st);
    step_t e;
    for (int i = 0; i < 5; i++) begin
      e = blank(st);
      e.exp.halted = (st == S_HALT);
      e.exp.memErr = (st == S_ERROR);
      plan.push_back(e);
    end
    planSticky = 1'b1;
  endtask

  // Expected cycle-by-cycle behaviour of one instruction: fw fetch waits,
  // mw data-memory waits, then the class-specific state walk.
  task automatic buildPlan(input int cls, input int fw, input int mw);
    step_t e;
    int    nw;
    plan.delete();
    planSticky = 1'b0;
    planInstr  = makeInstr(cls);
    nw = (fw < WAIT_LIMIT) ? fw : WAIT_LIMIT;
    for (int i = 0; i < nw; i++) begin
      e = blank(S_FETCH);
      e.imemRdy = 1'b0;
      e.exp.imemReq = 1'b1;
      plan.push_back(e);
    end
    if (fw >= WAIT_LIMIT) begin
      addSticky(S_ERROR);
      return;
    end
    e = blank(S_FETCH);
    e.imemRdy = 1'b1;
    e.exp.imemReq = 1'b1;
    e.exp.irW = 1'b1;
    e.exp.pcW = 1'b1;
    plan.push_back(e);
    e = blank(S_DECODE);
    case (cls)
      C_J, C_JAL: begin e.exp.pcW = 1'b1; e.exp.pcSrc = 2'd2; end
      C_JR:       begin e.exp.pcW = 1'b1; e.exp.pcSrc = 2'd3; end
      default: ;
    endcase
    plan.push_back(e);
    case (cls)
      C_SYSCALL:          addSticky(S_HALT);
      C_J, C_JR, C_OTHER: ;
      C_JAL:              addWb();
      default: begin
        e = blank(S_EXEC);
        if (cls == C_BEQ) begin
          e.exp.pcWC  = 1'b1;
          e.exp.pcSrc = 2'd1;
        end
        plan.push_back(e);
        if (cls == C_LW || cls == C_SW) begin
          nw = (mw < WAIT_LIMIT) ? mw : WAIT_LIMIT;
          for (int i = 0; i <= nw; i++) begin
            if (i == nw && mw >= WAIT_LIMIT) begin
              addSticky(S_ERROR);
              return;
            end
            e = blank(S_MEM);
            e.dmRdy = (i == nw);
            e.exp.dmReq = 1'b1;
            e.exp.dmW = (cls == C_SW);
            plan.push_back(e);
          end
          if (cls == C_LW) addWb();
        end else if (cls != C_BEQ) begin
          addWb();
        end
      end
    endcase
  endtask

  task automatic forceReady(input logic z);
    step_t e;
    for (int i = 0; i < plan.size(); i++) begin
      e = plan[i];
      e.imemRdy = 1'b1;
      e.dmRdy   = 1'b1;
      e.zero    = z;
      plan[i]   = e;
    end
  endtask

  // Starts at posedge+1; stops at the sampling negedge of cycle stopAfter.
  task automatic applyStimulus(input int stopAfter);
    obsQ.delete();
    for (int i = 0; i < plan.size(); i++) begin
      instruction = planInstr;
      imem_ready  = plan[i].imemRdy;
      dm_ready    = plan[i].dmRdy;
      zero        = plan[i].zero;
      @(negedge clk);
      obsQ.push_back(sample());
      checkOutput($sformatf("cycle%0d", i), obsQ[i], plan[i].exp);
      if (i == stopAfter) return;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset();
    obs_t zeroObs;
    zeroObs = '0;
    #2 rst_n = 1'b0;
    #1 checkOutput("resetAsync", sample(), zeroObs);
    @(negedge clk);
    checkOutput("resetHold", sample(), zeroObs);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("resetRelease", sample(), zeroObs);
    @(posedge clk);
    #1;
  endtask

  task automatic checkLits(input string name);
    for (int i = 0; i < litQ.size(); i++) begin
      if (i < obsQ.size()) checkValue($sformatf("%s_state%0d", name, i), int'(obsQ[i].st), litQ[i]);
      else                 checkValue($sformatf("%s_state%0d", name, i), -1, litQ[i]);
    end
  endtask

  function automatic int countWhere(input int field, input int val);
    int n = 0;
    foreach (obsQ[i]) begin
      case (field)
        0: if (int'(obsQ[i].st) == val) n++;
        1: if (obsQ[i].gprW) n++;
        default: if (obsQ[i].dmW) n++;
      endcase
    end
    return n;
  endfunction

  function automatic int pickWait();
    int r = $urandom_range(0, 99);
    if (r < 4)  return WAIT_LIMIT + $urandom_range(0, 2);
    if (r < 8)  return WAIT_LIMIT - 1;
    return $urandom_range(0, 3);
  endfunction

  initial begin
    int cls, fw, mw;
    doReset();

    $display("[TB] addu with ready tied high");
    buildPlan(C_RTYPE, 0, 0);
    planInstr = 32'h0123_4821;
    forceReady(1'b0);
    applyStimulus(-1);
    litQ = '{0, 1, 2, 4};
    checkLits("addu");
    checkValue("addu_gprCycles", countWhere(1, 0), 1);
    checkValue("addu_gprInWb", int'(obsQ[3].gprW), 1);

    $display("[TB] lw with three memory waits");
    buildPlan(C_LW, 0, 3);
    applyStimulus(-1);
    litQ = '{0, 1, 2, 3, 3, 3, 3, 4};
    checkLits("lw");
    checkValue("lw_noWrite", countWhere(2, 0), 0);

    $display("[TB] beq with zero low then high");
    for (int z = 0; z < 2; z++) begin
      buildPlan(C_BEQ, 0, 0);
      forceReady(1'(z));
      applyStimulus(-1);
      litQ = '{0, 1, 2};
      checkLits($sformatf("beq_z%0d", z));
      checkValue($sformatf("beq_z%0d_cond", z), int'(obsQ[2].pcWC), 1);
      checkValue($sformatf("beq_z%0d_src", z), int'(obsQ[2].pcSrc), 1);
    end

    $display("[TB] j and jal latencies");
    buildPlan(C_J, 0, 0);
    applyStimulus(-1);
    litQ = '{0, 1};
    checkLits("j");
    buildPlan(C_JAL, 0, 0);
    applyStimulus(-1);
    litQ = '{0, 1, 4};
    checkLits("jal");

    $display("[TB] lw ready on the last allowed wait cycle");
    buildPlan(C_LW, 0, WAIT_LIMIT - 1);
    applyStimulus(-1);
    checkValue("lwEdge_memCycles", countWhere(0, S_MEM), WAIT_LIMIT);
    checkValue("lwEdge_wb", int'(obsQ[obsQ.size() - 1].st), S_WB);

    $display("[TB] sw data memory timeout");
    buildPlan(C_SW, 0, 20);
    applyStimulus(-1);
    checkValue("swTimeout_memCycles", countWhere(0, S_MEM), 15);
    checkValue("swTimeout_state", int'(obsQ[18].st), S_ERROR);
    checkValue("swTimeout_memError", int'(obsQ[18].memErr), 1);
    checkValue("swTimeout_sticky", int'(obsQ[22].st), S_ERROR);
    doReset();

    $display("[TB] fetch timeout");
    buildPlan(C_ORI, 20, 0);
    applyStimulus(-1);
    checkValue("fetchTimeout_state", int'(obsQ[15].st), S_ERROR);
    doReset();

    $display("[TB] syscall halts");
    buildPlan(C_SYSCALL, 1, 0);
    applyStimulus(-1);
    checkValue("syscall_state", int'(obsQ[3].st), S_HALT);
    checkValue("syscall_halted", int'(obsQ[6].halted), 1);
    doReset();

    $display("[TB] reset during sw memory write");
    buildPlan(C_SW, 0, 6);
    applyStimulus(4);
    checkValue("swMem_writeBeforeReset", int'(obsQ[4].dmW), 1);
    doReset();

    $display("[TB] randomized instruction stream");
    for (int t = 0; t < 300; t++) begin
      cls = $urandom_range(0, 10);
      fw  = pickWait();
      mw  = pickWait();
      buildPlan(cls, fw, mw);
      if ($urandom_range(0, 19) == 0) begin
        applyStimulus($urandom_range(0, plan.size() - 1));
        doReset();
      end else begin
        applyStimulus(-1);
        if (planSticky) doReset();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
